// File: rtl/memory_access_unit.sv
// Memory-stage bus initiator: turns a load/store request into a handshaked data-bus
// transaction, stalls the pipeline while it is outstanding and returns extended load data.
module memory_access_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read_memory,
  input  logic                  mem_write_memory,
  input  logic [1:0]            mem_size_memory,
  input  logic                  load_unsigned_memory,
  input  logic [ADDR_WIDTH-1:0] address_memory,
  input  logic [31:0]           write_data_memory,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic                  bus_read,
  output logic                  bus_write,
  output logic [3:0]            bus_byteenable,
  output logic [31:0]           bus_writedata,
  input  logic [31:0]           bus_readdata,
  input  logic                  bus_waitrequest,
  output logic [31:0]           read_data_memory,
  output logic                  stall_memory,
  output logic                  misaligned_memory
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      r_state, w_state_next;
  logic        w_request, w_misaligned, w_load, w_capture;
  logic [3:0]  w_byteenable;
  logic [31:0] w_writedata, w_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [1:0]  r_size, r_lane;
  logic        r_unsigned;

  assign w_request = mem_read_memory | mem_write_memory;

  // Lane selection, store replication and alignment check for the incoming request
  always_comb begin
    w_byteenable = 4'b1111;
    w_writedata  = write_data_memory;
    w_misaligned = |address_memory[1:0];
    case (mem_size_memory)
      2'd0: begin
        w_byteenable = 4'(4'b0001 << address_memory[1:0]);
        w_writedata  = {4{write_data_memory[7:0]}};
        w_misaligned = 1'b0;
      end
      2'd1: begin
        w_byteenable = address_memory[1] ? 4'b1100 : 4'b0011;
        w_writedata  = {2{write_data_memory[15:0]}};
        w_misaligned = address_memory[0];
      end
      default: ;
    endcase
  end

  // Load extension uses the size/lane captured when the access was launched
  assign w_byte = bus_readdata[{r_lane, 3'b000} +: 8];
  assign w_half = r_lane[1] ? bus_readdata[31:16] : bus_readdata[15:0];

  always_comb begin
    case (r_size)
      2'd0:    w_ext = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'd1:    w_ext = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ext = bus_readdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next      = r_state;
    stall_memory      = 1'b0;
    misaligned_memory = 1'b0;
    w_load            = 1'b0;
    w_capture         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_request) begin
          if (w_misaligned) begin
            misaligned_memory = 1'b1;
          end else begin
            stall_memory = 1'b1;
            w_load       = 1'b1;
            w_state_next = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        stall_memory = 1'b1;
        if (!bus_waitrequest) begin
          w_capture    = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Bus request registers; a read wins over a simultaneous write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_address      <= '0;
      bus_read         <= 1'b0;
      bus_write        <= 1'b0;
      bus_byteenable   <= 4'd0;
      bus_writedata    <= 32'd0;
      read_data_memory <= 32'd0;
      r_size           <= 2'd0;
      r_lane           <= 2'd0;
      r_unsigned       <= 1'b0;
    end else if (w_load) begin
      bus_address    <= {address_memory[ADDR_WIDTH-1:2], 2'b00};
      bus_read       <= mem_read_memory;
      bus_write      <= ~mem_read_memory;
      bus_byteenable <= w_byteenable;
      bus_writedata  <= w_writedata;
      r_size         <= mem_size_memory;
      r_lane         <= address_memory[1:0];
      r_unsigned     <= load_unsigned_memory;
    end else if (w_capture) begin
      bus_read  <= 1'b0;
      bus_write <= 1'b0;
      if (bus_read) read_data_memory <= w_ext;
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: directed scenarios plus randomized accesses checked
// against a transaction-level reference model of lanes, replication and extension.
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_memory, mem_write_memory, load_unsigned_memory, bus_waitrequest;
  logic [1:0]  mem_size_memory;
  logic [31:0] address_memory, write_data_memory, bus_readdata;
  logic [31:0] bus_address, bus_writedata, read_data_memory;
  logic        bus_read, bus_write, stall_memory, misaligned_memory;
  logic [3:0]  bus_byteenable;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_rdata = 32'd0;

  memory_access_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .mem_read_memory(mem_read_memory), .mem_write_memory(mem_write_memory),
    .mem_size_memory(mem_size_memory), .load_unsigned_memory(load_unsigned_memory),
    .address_memory(address_memory), .write_data_memory(write_data_memory),
    .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
    .bus_byteenable(bus_byteenable), .bus_writedata(bus_writedata),
    .bus_readdata(bus_readdata), .bus_waitrequest(bus_waitrequest),
    .read_data_memory(read_data_memory), .stall_memory(stall_memory),
    .misaligned_memory(misaligned_memory)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: an access touches nbytes bytes starting at byte offset addr%4
  task automatic model(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdata, input logic uns,
                       output logic mis, output logic [3:0] be, output logic [31:0] wdata,
                       output logic [31:0] rval);
    int nbytes, off;
    logic [31:0] v;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off    = int'(addr % 4);
    mis    = (off % nbytes) != 0;
    be     = 4'(((1 << nbytes) - 1) << off);
    for (int k = 0; k < 4; k++) wdata[8*k +: 8] = wd[8*(k % nbytes) +: 8];
    v = rdata >> (8 * off);
    if (nbytes < 4) begin
      v = v & ((32'd1 << (8 * nbytes)) - 32'd1);
      if (!uns && v[8*nbytes-1]) v = v | ~((32'd1 << (8 * nbytes)) - 32'd1);
    end
    rval = v;
  endtask

  task automatic drive_idle();
    mem_read_memory = 0; mem_write_memory = 0; mem_size_memory = 0;
    load_unsigned_memory = 0; address_memory = 0; write_data_memory = 0;
  endtask

  // Called just after a posedge with the DUT in IDLE; returns just after a posedge in IDLE
  task automatic access(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int waits);
    logic mis; logic [3:0] be; logic [31:0] wdata, rval;
    int stalls;
    model(size, addr, wd, rdata, uns, mis, be, wdata, rval);
    mem_read_memory = rd; mem_write_memory = wr; mem_size_memory = size;
    load_unsigned_memory = uns; address_memory = addr; write_data_memory = wd;
    bus_readdata = rdata; bus_waitrequest = 1'b0;
    @(negedge clk);
    if (!(rd | wr)) begin
      chk("idle_stall", 32'(stall_memory), 32'd0);
      chk("idle_strobes", {30'd0, bus_read, bus_write}, 32'd0);
      chk("idle_misaligned", 32'(misaligned_memory), 32'd0);
      @(posedge clk); #1;
      return;
    end
    if (mis) begin
      chk("mis_flag", 32'(misaligned_memory), 32'd1);
      chk("mis_stall", 32'(stall_memory), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mis_strobes", {30'd0, bus_read, bus_write}, 32'd0);
      drive_idle();
      @(posedge clk); #1;
      return;
    end
    chk("req_misaligned", 32'(misaligned_memory), 32'd0);
    stalls = int'(stall_memory);
    for (int c = 0; c <= waits; c++) begin
      @(posedge clk); #1;
      bus_waitrequest = (c < waits);
      @(negedge clk);
      chk("acc_strobes", {30'd0, bus_read, bus_write}, rd ? 32'd2 : 32'd1);
      chk("acc_address", bus_address, addr & 32'hFFFF_FFFC);
      chk("acc_byteenable", 32'(bus_byteenable), 32'(be));
      chk("acc_writedata", bus_writedata, wdata);
      chk("acc_misaligned", 32'(misaligned_memory), 32'd0);
      stalls += int'(stall_memory);
    end
    if (rd) exp_rdata = rval;
    @(posedge clk); #1;
    bus_waitrequest = 1'b0;
    @(negedge clk);
    chk("done_stall", 32'(stall_memory), 32'd0);
    chk("done_strobes", {30'd0, bus_read, bus_write}, 32'd0);
    chk("done_read_data", read_data_memory, exp_rdata);
    chk("stall_cycles", 32'(stalls), 32'(waits + 2));
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; bus_waitrequest = 1'b0; bus_readdata = 32'd0;
    drive_idle();
    @(negedge clk);
    chk("rst_strobes", {30'd0, bus_read, bus_write}, 32'd0);
    chk("rst_address", bus_address, 32'd0);
    chk("rst_byteenable", 32'(bus_byteenable), 32'd0);
    chk("rst_writedata", bus_writedata, 32'd0);
    chk("rst_read_data", read_data_memory, 32'd0);
    chk("rst_stall", 32'(stall_memory), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    access(1, 0, 2'd2, 0, 32'h0000_0104, 32'd0, 32'hDEAD_BEEF, 0);   // lw

    // Reset during a stalled read aborts it asynchronously
    mem_read_memory = 1; mem_size_memory = 2'd2; address_memory = 32'h0000_0200;
    bus_waitrequest = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_pre_read", 32'(bus_read), 32'd1);
    #2;
    reset = 1'b1; drive_idle();
    #1;
    chk("abort_read", 32'(bus_read), 32'd0);
    chk("abort_stall", 32'(stall_memory), 32'd0);
    chk("abort_read_data", read_data_memory, 32'd0);
    exp_rdata = 32'd0;
    @(posedge clk); #1;
    reset = 1'b0; bus_waitrequest = 1'b0;
    @(posedge clk); #1;
    access(0, 0, 2'd0, 0, 32'd0, 32'd0, 32'd0, 0);                   // confirms IDLE

    access(1, 0, 2'd0, 0, 32'h0000_0203, 32'd0, 32'h80FF_7F01, 0);   // lb
    chk("lb_value", read_data_memory, 32'hFFFF_FF80);
    access(1, 0, 2'd0, 1, 32'h0000_0203, 32'd0, 32'h80FF_7F01, 0);   // lbu
    chk("lbu_value", read_data_memory, 32'h0000_0080);
    access(0, 1, 2'd1, 0, 32'h0000_0012, 32'h0000_ABCD, 32'd0, 3);   // sh, 3 waits
    access(1, 0, 2'd2, 0, 32'h0000_0102, 32'd0, 32'd0, 0);           // misaligned lw
    access(1, 0, 2'd1, 0, 32'h0000_0101, 32'd0, 32'd0, 0);           // misaligned lh
    access(1, 0, 2'd2, 0, 32'h0000_0008, 32'd0, 32'hCAFE_F00D, 0);   // lw, then sw back-to-back
    access(0, 1, 2'd2, 0, 32'h0000_0008, 32'h1234_5678, 32'd0, 0);
    chk("b2b_read_hold", read_data_memory, 32'hCAFE_F00D);
    access(1, 1, 2'd1, 0, 32'h0000_0036, 32'h0000_5555, 32'h8001_7FFF, 1); // read wins
    drive_idle();

    for (int i = 0; i < 60; i++) begin
      logic rd, wr, uns;
      logic [1:0] size;
      rd   = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      access(rd, wr, size, uns, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
    end
    drive_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- Memory-stage bus initiator. It turns the memory-stage load/store request into a handshaked transaction on the data bus (address, read, write, byteenable, writedata, waitrequest).
- It produces read_data_memory, the load data that the memory/writeback pipeline register captures.
- It stalls the pipeline while a bus access is outstanding.
- It sits between the execute/memory pipeline register and the memory/writeback pipeline register.

Parameters:
- ADDR_WIDTH, 32, byte-address width of core and bus address.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- mem_read_memory  input  1  current memory-stage instruction is a load.
- mem_write_memory  input  1  current memory-stage instruction is a store.
- mem_size_memory  input  2  access size: 0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- load_unsigned_memory  input  1  1 = zero-extend byte/half load; 0 = sign-extend.
- address_memory  input  ADDR_WIDTH  byte address from the ALU.
- write_data_memory  input  32  store data, right-justified.
- bus_address  output  ADDR_WIDTH  word-aligned address; bits [1:0] are always 0.
- bus_read  output  1  read strobe.
- bus_write  output  1  write strobe.
- bus_byteenable  output  4  byte-lane enables.
- bus_writedata  output  32  lane-replicated store data.
- bus_readdata  input  32  read data, valid in the cycle bus_read=1 and bus_waitrequest=0.
- bus_waitrequest  input  1  slave not ready; hold request.
- read_data_memory  output  32  extended load result.
- stall_memory  output  1  freeze the fetch, decode, execute and memory stages.
- misaligned_memory  output  1  misaligned access flag.

Behaviour:
- Clocking and reset: clk and reset as in ports; reset is asynchronous and active-high.
- Reset values: state IDLE, bus_read=0, bus_write=0, bus_address=0, bus_byteenable=0, bus_writedata=0, read_data_memory=0.
- Reset mid-transaction: reset aborts the transaction immediately and drops the strobes. No completion is reported.
- Byte lanes: lane k is selected when address[1:0]=k; it maps to byteenable[k] and data bits [8k+7:8k].
- Byteenable:
  - byte: 1<<addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- Writedata:
  - byte: {4{wd[7:0]}}
  - half: {2{wd[15:0]}}
  - word: wd
- Misalignment:
  - Condition: half with addr[0]=1, or word with addr[1:0]!=0.
  - In IDLE with a request: misaligned_memory=1 (combinational), stall_memory=0, no bus transaction.
  - misaligned_memory is 0 at all other times.
- Simultaneous read and write request: handled as a read; the store is dropped.
- Request: mem_read_memory | mem_write_memory. A request is "aligned" when it is not misaligned.
- FSM, IDLE:
  - stall_memory = aligned request.
  - On an aligned request: register bus_address={addr[31:2],2'b00}, byteenable, writedata and the strobe; go to ACCESS.
- FSM, ACCESS:
  - bus_read or bus_write is held high; all bus outputs are held stable while bus_waitrequest=1.
  - stall_memory=1.
  - When bus_waitrequest=0: clear the strobe next edge; for a read, capture the extended lane data into read_data_memory; go to DONE.
- FSM, DONE:
  - stall_memory=0 so the pipeline advances and the memory/writeback register samples read_data_memory.
  - Request inputs are ignored (same instruction still present); always go to IDLE next edge.
- Extension: byte/half lane data is sign- or zero-extended per load_unsigned; a word is passed through.
- read_data_memory holds its value until the next read completes.
- Latency: aligned access with zero wait states takes 3 cycles (IDLE, ACCESS, DONE); each waitrequest cycle adds 1.
- No request in IDLE: all strobes are 0 and stall_memory=0.

Test Plan:
- Reset during ACCESS with bus_waitrequest=1 -> bus_read drops to 0 asynchronously; state IDLE; read_data_memory=0; stall_memory=0.
- lw, addr 0x00000104, readdata 0xDEADBEEF, no waits:
  - cycle 1: bus_read=1, bus_address=0x104, byteenable=4'b1111
  - DONE cycle: read_data_memory=0xDEADBEEF, stall_memory=0
  - stall_memory=1 for exactly 2 cycles.
- lb, addr 0x00000203, signed, readdata 0x80FF7F01 -> byteenable=4'b1000, read_data=0xFFFFFF80.
  - Same access with lbu -> read_data=0x00000080.
- sh, addr 0x00000012, wd 0x0000ABCD, bus_waitrequest=1 for 3 cycles:
  - bus_write=1 and outputs stable all 4 cycles
  - byteenable=4'b1100, writedata=0xABCDABCD
  - stall_memory=1 for 5 cycles total.
- lw at 0x00000102 -> misaligned_memory=1, bus_read never asserts, stall_memory=0.
  - lh at 0x00000101 -> same response.
- Back-to-back: lw then sw at 0x8, wd 0x12345678 -> DONE ignores the stale request, the store starts from IDLE next cycle, writedata=0x12345678.
